serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that computes a WIDTH-bit sum by sequencing a single 1-bit full adder, LSB first, one bit per clock. It latches operands on a start handshake, runs a shift/count state machine, and returns a registered sum and carry-out with a one-cycle done pulse. It is the lab datapath's multi-bit adder wherever area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder_1bit.sv | 14 +
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  // Controller states: waiting for a request, shifting bits, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand/result width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_1bit.sv
// Purely combinational 1-bit full adder, the only arithmetic element of the
// serial adder datapath.
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic carry_in,
  output logic S,
  output logic carry_out
);

  assign S         = A ^ B ^ carry_in;
  assign carry_out = (A & B) | (carry_in & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = a + b + cin one bit per
// clock, LSB first, by sequencing a single full_adder_1bit.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' port selecting a - b.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1; a, b, cin (and sub) are sampled at that edge. start while ready=0
// is ignored and never queued. done pulses for one cycle when sum/cout update.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder_1bit u_fa (
    .A         (a_sr[0]),
    .B         (b_sr[0]),
    .carry_in  (carry),
    .S         (fa_s),
    .carry_out (fa_co)
  );

  assign last_bit  = (cnt == LAST_BIT);
  assign fsm_state = state;

  // Operand B / carry values captured at acceptance; subtraction is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  // Partial sum shifted right with the new sum bit entering at the MSB.
  always_comb begin
    psum_next            = psum >> 1;
    psum_next[WIDTH-1]   = fa_s;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one RUN cycle per bit, then a single DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: latch on accept, shift/accumulate in RUN, publish on last bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          psum  <= psum_next;
          if (last_bit) begin
            sum  <= psum_next;
            cout <= fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance for directed
// timing/handshake/reset cases and a 4-bit instance for an exhaustive sweep.
module tb_serial_adder_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic       start8, cin8, sub8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;
  logic       start4, cin4, sub4, ready4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fsm_state(st8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clock(clock), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fsm_state(st4)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] e8;
  logic [4:0] e4;
  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  int done4_cnt = 0;
  logic prev8 = 1'b0;
  logic prev4 = 1'b0;
  int n0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitors: pop the expected value on every done pulse.
  always @(negedge clock) begin
    if (!reset && done8) begin
      done8_cnt++;
      check("done8_single_cycle", 32'(prev8), 0);
      check("done8_pending", 32'(exp8_q.size() != 0), 1);
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        check("result8", {23'd0, cout8, sum8}, {23'd0, e8});
      end
    end
    prev8 = done8;
  end

  always @(negedge clock) begin
    if (!reset && done4) begin
      done4_cnt++;
      check("done4_single_cycle", 32'(prev4), 0);
      check("done4_pending", 32'(exp4_q.size() != 0), 1);
      if (exp4_q.size() != 0) begin
        e4 = exp4_q.pop_front();
        check("result4", {27'd0, cout4, sum4}, {27'd0, e4});
      end
    end
    prev4 = done4;
  end

  // ---------------- driver tasks ----------------
  // Drive a request at a negedge; returns #1 after the accepting posedge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input bit push);
    @(negedge clock);
    for (int i = 0; i < 40 && !ready8; i++) @(negedge clock);
    check("ready8_before_start", 32'(ready8), 1);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub8 = s;
    if (push) begin
      if (s) exp8_q.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
      else   exp8_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    end
    @(posedge clock); #1;
    start8 = 1'b0;
  endtask

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clock);
    for (int i = 0; i < 20 && !ready4; i++) @(negedge clock);
    check("ready4_before_start", 32'(ready4), 1);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c; sub4 = 1'b0;
    exp4_q.push_back({1'b0, a} + {1'b0, b} + {4'd0, c});
    @(posedge clock); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done8(input int n);
    for (int i = 0; i < 40 && done8_cnt == n; i++) begin
      @(negedge clock); #2;
    end
    check("done8_seen", done8_cnt, n + 1);
  endtask

  task automatic wait_done4(input int n);
    for (int i = 0; i < 20 && done4_cnt == n; i++) begin
      @(negedge clock); #2;
    end
    check("done4_seen", done4_cnt, n + 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(ready8), 1);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_sum", 32'(sum8), 0);
    check("rst_cout", 32'(cout8), 0);
    @(negedge clock) reset = 1'b0;

    // 0x0F + 0x01: cycle-accurate timing of busy/done/ready.
    launch8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    check("t1_busy_after_accept", 32'(busy8), 1);
    check("t1_ready_low", 32'(ready8), 0);
    repeat (7) @(posedge clock);
    #1;
    check("t1_busy_last_bit", 32'(busy8), 1);
    check("t1_no_early_done", 32'(done8), 0);
    @(posedge clock); #1;
    check("t1_done", 32'(done8), 1);
    check("t1_busy_off", 32'(busy8), 0);
    check("t1_sum", 32'(sum8), 32'h10);
    check("t1_cout", 32'(cout8), 0);
    @(posedge clock); #1;
    check("t1_ready_back", 32'(ready8), 1);
    check("t1_done_off", 32'(done8), 0);
    check("t1_sum_held", 32'(sum8), 32'h10);

    // Carry-out cases.
    n0 = done8_cnt;
    launch8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done8(n0);
    n0 = done8_cnt;
    launch8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    wait_done8(n0);

    // start during RUN is ignored.
    n0 = done8_cnt;
    launch8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clock);
    start8 = 1'b0;
    wait_done8(n0);
    repeat (12) @(negedge clock);
    #2;
    check("ignored_start_one_done", done8_cnt, n0 + 1);
    check("ignored_start_q_empty", 32'(exp8_q.size()), 0);
    check("ignored_start_sum", 32'(sum8), 32'h46);

    // Reset 3 cycles into RUN aborts the operation.
    n0 = done8_cnt;
    launch8(8'h55, 8'h22, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("abort_busy_before", 32'(busy8), 1);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready8), 1);
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_sum", 32'(sum8), 0);
    check("abort_cout", 32'(cout8), 0);
    @(negedge clock) reset = 1'b0;
    repeat (15) @(negedge clock);
    #2;
    check("abort_no_done", done8_cnt, n0);
    n0 = done8_cnt;
    launch8(8'h55, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_done8(n0);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: cout=1 means no borrow.
    n0 = done8_cnt;
    launch8(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_done8(n0);
    check("sub_5_7_sum", 32'(sum8), 32'hFE);
    check("sub_5_7_cout", 32'(cout8), 0);
    n0 = done8_cnt;
    launch8(8'h07, 8'h05, 1'b0, 1'b1, 1'b1);
    wait_done8(n0);
    check("sub_7_5_sum", 32'(sum8), 32'h02);
    check("sub_7_5_cout", 32'(cout8), 1);
`endif

    // A few random 8-bit additions.
    for (int i = 0; i < 8; i++) begin
      n0 = done8_cnt;
      launch8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'b0, 1'b1);
      wait_done8(n0);
    end

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          n0 = done4_cnt;
          launch4(4'(a), 4'(b), 1'(c));
          wait_done4(n0);
        end
      end
    end
    repeat (4) @(negedge clock);
    #2;
    check("sweep4_done_count", done4_cnt, 512);
    check("sweep4_q_empty", 32'(exp4_q.size()), 0);
    check("final8_q_empty", 32'(exp8_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
